// File: rtl/div_pkg.sv
// Shared types and constants for the iterative MIPS DIV/DIVU unit.
package div_pkg;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_RUN  = 2'd1,
        DIV_DONE = 2'd2
    } div_state_e;

    localparam int unsigned DIV_WIDTH = 32;
    localparam int unsigned DIV_CNT_W = 6;

    // MIPS funct codes; the control unit drives is_signed from these.
    localparam logic [5:0] FUNCT_DIV  = 6'h1A;
    localparam logic [5:0] FUNCT_DIVU = 6'h1B;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step on {rem, q}.
module div_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic [WIDTH-1:0] q_i,
    input  logic [WIDTH-1:0] divisor_mag_i,
    output logic [WIDTH-1:0] rem_o,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH:0] rem_sh;
    logic [WIDTH:0] trial;

    // rem < divisor_mag, so the shifted value minus divisor_mag always fits
    // in WIDTH+1 signed bits and trial[WIDTH] is a valid sign.
    always_comb begin
        rem_sh = {rem_i, q_i[WIDTH-1]};
        trial  = rem_sh - {1'b0, divisor_mag_i};
        rem_o  = trial[WIDTH] ? rem_sh[WIDTH-1:0] : trial[WIDTH-1:0];
        q_o    = {q_i[WIDTH-2:0], ~trial[WIDTH]};
    end

endmodule

// File: rtl/iter_div.sv
// Iterative restoring divider for MIPS DIV/DIVU: one quotient bit per cycle,
// results held until the next accepted start.
module iter_div
    import div_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH,
    parameter int unsigned CNT_W = DIV_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             done,
    output logic             div_zero
);

    div_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] dmag_q, dmag_d;
    logic             sign_q_q, sign_q_d;
    logic             sign_r_q, sign_r_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] remo_q, remo_d;
    logic             dz_q, dz_d;

    logic [WIDTH-1:0] step_rem, step_q;
    logic             neg_a, neg_b;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_i         (rem_q),
        .q_i           (acc_q),
        .divisor_mag_i (dmag_q),
        .rem_o         (step_rem),
        .q_o           (step_q)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= DIV_IDLE;
            cnt_q    <= '0;
            rem_q    <= '0;
            acc_q    <= '0;
            dmag_q   <= '0;
            sign_q_q <= 1'b0;
            sign_r_q <= 1'b0;
            quot_q   <= '0;
            remo_q   <= '0;
            dz_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rem_q    <= rem_d;
            acc_q    <= acc_d;
            dmag_q   <= dmag_d;
            sign_q_q <= sign_q_d;
            sign_r_q <= sign_r_d;
            quot_q   <= quot_d;
            remo_q   <= remo_d;
            dz_q     <= dz_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rem_d    = rem_q;
        acc_d    = acc_q;
        dmag_d   = dmag_q;
        sign_q_d = sign_q_q;
        sign_r_d = sign_r_q;
        quot_d   = quot_q;
        remo_d   = remo_q;
        dz_d     = dz_q;
        neg_a    = is_signed & dividend[WIDTH-1];
        neg_b    = is_signed & divisor[WIDTH-1];

        case (state_q)
            DIV_IDLE, DIV_DONE: begin
                state_d = DIV_IDLE;
                if (start) begin
                    if (divisor == '0) begin
                        state_d = DIV_DONE;
                        quot_d  = '1;
                        remo_d  = dividend;
                        dz_d    = 1'b1;
                    end else begin
                        state_d  = DIV_RUN;
                        acc_d    = neg_a ? -dividend : dividend;
                        dmag_d   = neg_b ? -divisor : divisor;
                        sign_q_d = neg_a ^ neg_b;
                        sign_r_d = neg_a;
                        rem_d    = '0;
                        cnt_d    = '0;
                    end
                end
            end
            DIV_RUN: begin
                rem_d = step_rem;
                acc_d = step_q;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = DIV_DONE;
                    quot_d  = sign_q_q ? -step_q : step_q;
                    remo_d  = sign_r_q ? -step_rem : step_rem;
                    dz_d    = 1'b0;
                end
            end
            default: state_d = DIV_IDLE;
        endcase
    end

    assign quotient  = quot_q;
    assign remainder = remo_q;
    assign div_zero  = dz_q;
    assign busy      = (state_q == DIV_RUN);
    assign done      = (state_q == DIV_DONE);

endmodule
